// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, status flags and the FIFO entry layout.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 16;
  localparam int unsigned ALU_SEL_W  = 4;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SL   = 4'b1000;
  localparam logic [3:0] OP_SR   = 4'b1001;
  localparam logic [3:0] OP_LAST = 4'b1001;

  typedef struct packed {
    logic inv;
    logic dz;
    logic neg;
    logic zero;
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic [ALU_SEL_W-1:0]  sel;
    alu_flags_t            flags;
  } alu_entry_t;

  localparam int unsigned FLAGS_W = $bits(alu_flags_t);

endpackage

// File: rtl/alu_flag_gen.sv
// Sanitises an ALU result (illegal opcode / divide by zero -> 0) and derives its status flags.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 4
) (
  input  logic [DATA_W-1:0] result,
  input  logic [SEL_W-1:0]  sel,
  input  logic              b_zero,
  output logic [DATA_W-1:0] san_result_c,
  output alu_flags_t        flags_c
);

  // The ALU drives X for opcodes past OP_LAST and for division by zero.
  always_comb begin
    flags_c      = '0;
    flags_c.inv  = (sel > SEL_W'(OP_LAST));
    flags_c.dz   = (sel == SEL_W'(OP_DIV)) && b_zero;
    san_result_c = (flags_c.inv || flags_c.dz) ? '0 : result;
    flags_c.neg  = san_result_c[DATA_W-1];
    flags_c.zero = (san_result_c == '0);
  end

endmodule

// File: rtl/alu_result_fifo.sv
// Buffers sanitised ALU results with opcode and flags behind a valid/ready FIFO.
// Optional divide-by-zero event counter: define ALU_RESULT_FIFO_STATS_EN.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_result,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       in_b_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_result,
  output logic [SEL_W-1:0]           out_sel,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 stat_dz_cnt
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW      = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = DATA_W + SEL_W + FLAGS_W;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [DATA_W-1:0]  san_result;
  alu_flags_t         new_flags;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  alu_flag_gen #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_flag_gen (
    .result       (in_result),
    .sel          (in_sel),
    .b_zero       (in_b_zero),
    .san_result_c (san_result),
    .flags_c      (new_flags)
  );

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {san_result, in_sel, new_flags};
  end

  // Head is read straight from storage so it holds steady during a stall.
  assign head       = mem[rd_ptr];
  assign out_result = empty ? '0 : head[ENTRY_W-1 -: DATA_W];
  assign out_sel    = empty ? '0 : head[FLAGS_W +: SEL_W];
  assign out_flags  = empty ? '0 : head[FLAGS_W-1:0];

`ifdef ALU_RESULT_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_dz_cnt <= '0;
    end else if (push && new_flags.dz && (stat_dz_cnt != 8'hFF)) begin
      stat_dz_cnt <= stat_dz_cnt + 8'd1;
    end
  end
`else
  assign stat_dz_cnt = 8'h00;
`endif

endmodule
